boot_loader_ctrl: RTL and testbench
===================================

// Module: boot_loader_ctrl
// PURPOSE
//  Sequences program boot over UART: consumes bytes from uart_rx, reads a 4-byte word-count header,
//  assembles following bytes into 32-bit instruction words and writes them to instruction memory
//  at consecutive addresses, then releases the CPU. After boot, forwards received bytes to the CPU
//  input port through a one-entry buffer. Sits in top between uart_rx and the core/imem.
// PARAMETERS
//  ADDR_W  14  imem word-address width; max program = 2**ADDR_W words
// PORTS
//  clk           in   1         system clock
//  rstn          in   1         asynchronous active-low reset
//  rx_data       in   8         byte from uart_rx
//  rx_ready      in   1         1-cycle pulse: rx_data valid
//  rx_ferr       in   1         framing error, qualified by rx_ready
//  imem_we       out  1         imem write strobe, 1 cycle
//  imem_addr     out  ADDR_W    imem word address
//  imem_wdata    out  32        imem write data
//  cpu_run       out  1         1 = CPU may fetch/execute; sticky until reset
//  load_err      out  1         sticky: boot failed
//  words_loaded  out  ADDR_W+1  count of words written so far
//  in_data       out  8         run-mode byte to CPU
//  in_valid      out  1         in_data holds an unconsumed byte
//  in_ready      in   1         CPU consumes in_data when in_valid & in_ready
//  overrun       out  1         sticky: run-mode byte dropped (buffer full)
// BEHAVIOUR
//  Reset (async, rstn=0): state=HDR, all outputs 0, byte_idx=0, word shift reg=0. Reset mid-load
//   aborts immediately; no further imem writes; reload restarts from header.
//  Byte order little-endian: 1st byte -> bits[7:0], 4th byte -> bits[31:24]; header same.
//  States: HDR -> LOAD -> RUN; HDR/LOAD -> ERR.
//   HDR: collect 4 bytes into N. On 4th byte: N==0 -> RUN; N>2**ADDR_W -> ERR; else LOAD.
//   LOAD: collect 4 bytes/word. Cycle after 4th byte's rx_ready: imem_we=1, imem_addr=words_loaded,
//    imem_wdata=word; words_loaded increments same edge. When words_loaded reaches N, next cycle
//    enter RUN (cpu_run=1 one cycle after last imem_we).
//   RUN: cpu_run=1. rx bytes go to buffer: if !in_valid or (in_valid&in_ready) same cycle, load
//    in_data, in_valid=1 next cycle; else drop byte, overrun=1. in_valid&in_ready w/o new byte ->
//    in_valid=0 next cycle. Bytes with rx_ferr=1 are discarded silently in RUN.
//   ERR: load_err=1, cpu_run=0, imem_we=0; ignore all rx until reset.
//  rx_ready with rx_ferr=1 in HDR/LOAD -> ERR next cycle; partial word not written.
//  rx_ready ignored in any cycle imem_we is asserted? No: rx_ready is captured every cycle;
//   back-to-back bytes (rx_ready 1 cycle apart) must be handled with no loss.
//  imem_addr/imem_wdata hold last written values when imem_we=0.
//  words_loaded saturates at N; never exceeds 2**ADDR_W.
// TESTING
//  T1 header 02 00 00 00, bytes 13 00 00 00 EF BE AD DE -> imem[0]=0x00000013, imem[1]=0xDEADBEEF,
//     2 imem_we pulses, cpu_run=1 one cycle after 2nd, words_loaded=2.
//  T2 header 00 00 00 00 -> no imem_we, cpu_run=1 cycle after 4th header byte.
//  T3 header 03 00 00 00, 1 word, then byte with rx_ferr=1 -> load_err=1, cpu_run stays 0,
//     exactly 1 imem_we; further bytes ignored.
//  T4 RUN, in_ready=0, bytes 41 then 42 -> in_data=41, in_valid=1, overrun=1; set in_ready=1 ->
//     in_valid=0 next cycle; new byte 43 with in_ready=1 same cycle as pop -> in_data=43, no overrun.
//  T5 ADDR_W=4, header 11 00 00 00 (N=17) -> load_err=1, no writes; rstn low mid-LOAD of valid
//     program -> outputs 0 immediately, reload from header succeeds.
//  T6 back-to-back rx_ready pulses every cycle for full 2-word program -> same result as T1.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// ---------------------------------------------------------------------------
// boot_loader_ctrl
//
// Purpose:
//   Boots the CPU over UART. The first four received bytes form a
//   little-endian word count N. The next 4*N bytes are packed little-endian
//   into 32-bit words and written to instruction memory at addresses 0..N-1.
//   After the last write the CPU is released (cpu_run). From then on every
//   received byte is forwarded to the CPU through a one-entry buffer.
//   A framing error during header/load, or a header with
//   N > 2**ADDR_W, parks the block in an error state until reset.
//
// Ports:
//   clk           system clock
//   rstn          asynchronous active-low reset
//   rx_data       byte from uart_rx, valid when rx_ready
//   rx_ready      1-cycle pulse: rx_data valid (may pulse every cycle)
//   rx_ferr       framing error, qualified by rx_ready
//   imem_we       imem write strobe, 1 cycle
//   imem_addr     imem word address (holds last written value)
//   imem_wdata    imem write data (holds last written value)
//   cpu_run       CPU may fetch/execute; sticky until reset
//   load_err      sticky: boot failed
//   words_loaded  number of words written so far (saturates at N)
//   in_data       run-mode byte to CPU
//   in_valid      in_data holds an unconsumed byte
//   in_ready      CPU consumes in_data when in_valid & in_ready
//   overrun       sticky: run-mode byte dropped because the buffer was full
// ---------------------------------------------------------------------------
module boot_loader_ctrl #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   input  logic              rx_ferr,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_run,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded,
   output logic [7:0]        in_data,
   output logic              in_valid,
   input  logic              in_ready,
   output logic              overrun
);

   localparam logic [1:0] ST_HDR  = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   // Largest legal program size, one bit wider than the header so the
   // comparison cannot wrap.
   localparam logic [32:0]     MAX_WORDS = 33'd1 << ADDR_W;
   localparam logic [ADDR_W:0] ONE_WORD  = (ADDR_W+1)'(1);

   logic [1:0]      state;
   logic [1:0]      byte_idx;
   logic [23:0]     shift_reg;   // the three most recent bytes of the word
   logic [ADDR_W:0] n_words;

   logic [31:0] assembled;
   logic        byte_ok;
   logic        byte_bad;
   logic        load_done;
   logic        run_mode;
   logic        pop;

   // Newest byte lands on top, so after four bytes the first byte sits in
   // bits [7:0]: little-endian assembly without a byte-index mux.
   assign assembled = {rx_data, shift_reg};
   assign byte_ok   = rx_ready & ~rx_ferr;
   assign byte_bad  = rx_ready &  rx_ferr;
   assign load_done = (state == ST_LOAD) && (words_loaded == n_words);
   // The cycle that finishes loading already belongs to run mode, so a byte
   // arriving back-to-back with the last program byte reaches the buffer.
   assign run_mode  = (state == ST_RUN) || load_done;
   assign pop       = in_valid & in_ready;

   // ---------------------------------------------------------------------
   // Header / load sequencer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= ST_HDR;
         byte_idx     <= 2'd0;
         shift_reg    <= 24'd0;
         n_words      <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= 32'd0;
         cpu_run      <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout sequential logic; the
         // default-low strobe below is overridden later in the same block to
         // form a single-cycle pulse without extra state.
         imem_we <= 1'b0;
         case (state)
            ST_HDR: begin
               if (byte_bad) begin
                  state    <= ST_ERR;
                  load_err <= 1'b1;
               end else if (byte_ok) begin
                  shift_reg <= assembled[31:8];
                  byte_idx  <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     if (assembled == 32'd0) begin
                        state   <= ST_RUN;
                        cpu_run <= 1'b1;
                     end else if ({1'b0, assembled} > MAX_WORDS) begin
                        state    <= ST_ERR;
                        load_err <= 1'b1;
                     end else begin
                        n_words <= assembled[ADDR_W:0];
                        state   <= ST_LOAD;
                     end
                  end
               end
            end
            ST_LOAD: begin
               if (load_done) begin
                  state   <= ST_RUN;
                  cpu_run <= 1'b1;
               end else if (byte_bad) begin
                  // Partial word is simply abandoned; nothing is written.
                  state    <= ST_ERR;
                  load_err <= 1'b1;
               end else if (byte_ok) begin
                  shift_reg <= assembled[31:8];
                  byte_idx  <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     imem_we      <= 1'b1;
                     imem_addr    <= words_loaded[ADDR_W-1:0];
                     imem_wdata   <= assembled;
                     words_loaded <= words_loaded + ONE_WORD;
                  end
               end
            end
            default: begin
               // ST_RUN and ST_ERR are terminal until reset.
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Run-mode one-entry byte buffer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_data  <= 8'd0;
         in_valid <= 1'b0;
         overrun  <= 1'b0;
      end else if (run_mode) begin
         if (byte_ok) begin
            // A byte may replace one that the CPU is taking this cycle.
            if (!in_valid || pop) begin
               in_data  <= rx_data;
               in_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (pop) begin
            in_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boot_loader_ctrl
//
// Scoreboard bench for boot_loader_ctrl. Two instances: dut_a with the
// default ADDR_W and dut_b with ADDR_W=4 for the program-size limits.
// Stimulus pushes expected imem writes and CPU bytes into queues; a monitor
// pops and compares them whenever the DUT presents a write or a handshake.
// ---------------------------------------------------------------------------
module tb_boot_loader_ctrl;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rstn_a = 1'b0;
   logic        rstn_b = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_ready = 1'b0;
   logic        rx_ferr = 1'b0;
   logic        sel_b = 1'b0;
   logic        in_ready = 1'b0;
   logic        rx_ready_a;
   logic        rx_ready_b;

   logic        we_a, run_a, err_a, in_valid_a, overrun_a;
   logic [13:0] addr_a;
   logic [31:0] wdata_a;
   logic [14:0] wl_a;
   logic [7:0]  in_data_a;

   logic        we_b, run_b, err_b, in_valid_b, overrun_b;
   logic [3:0]  addr_b;
   logic [31:0] wdata_b;
   logic [4:0]  wl_b;
   logic [7:0]  in_data_b;

   assign rx_ready_a = rx_ready & ~sel_b;
   assign rx_ready_b = rx_ready &  sel_b;

   boot_loader_ctrl #(.ADDR_W(14)) dut_a (
      .clk(clk), .rstn(rstn_a), .rx_data(rx_data), .rx_ready(rx_ready_a),
      .rx_ferr(rx_ferr), .imem_we(we_a), .imem_addr(addr_a),
      .imem_wdata(wdata_a), .cpu_run(run_a), .load_err(err_a),
      .words_loaded(wl_a), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(in_ready), .overrun(overrun_a)
   );

   boot_loader_ctrl #(.ADDR_W(4)) dut_b (
      .clk(clk), .rstn(rstn_b), .rx_data(rx_data), .rx_ready(rx_ready_b),
      .rx_ferr(rx_ferr), .imem_we(we_b), .imem_addr(addr_b),
      .imem_wdata(wdata_b), .cpu_run(run_b), .load_err(err_b),
      .words_loaded(wl_b), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(1'b0), .overrun(overrun_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;

   wr_t        exp_a[$];
   wr_t        exp_b[$];
   logic [7:0] exp_byte[$];

   int ncyc = 0;
   int we_cnt_a = 0;
   int we_cnt_b = 0;
   int last_we_a = 0;
   int run_at_a = 0;
   bit run_seen_a = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples just after the falling edge, when both DUT outputs
   // (from the last rising edge) and bench inputs (set on this falling edge)
   // are stable. A handshake seen here is consumed at the next rising edge.
   wr_t        e;
   logic [7:0] eb;
   initial begin
      forever begin
         @(negedge clk);
         #1;
         ncyc++;
         if (we_a) begin
            we_cnt_a++;
            last_we_a = ncyc;
            if (exp_a.size() == 0) begin
               check("a_unexpected_we", we_a, 1'b0);
            end else begin
               e = exp_a.pop_front();
               check("a_imem_addr", addr_a, e.addr);
               check("a_imem_wdata", wdata_a, e.data);
            end
         end
         if (we_b) begin
            we_cnt_b++;
            if (exp_b.size() == 0) begin
               check("b_unexpected_we", we_b, 1'b0);
            end else begin
               e = exp_b.pop_front();
               check("b_imem_addr", addr_b, e.addr);
               check("b_imem_wdata", wdata_b, e.data);
            end
         end
         if (in_valid_a && in_ready) begin
            if (exp_byte.size() == 0) begin
               check("a_unexpected_byte", in_valid_a, 1'b0);
            end else begin
               eb = exp_byte.pop_front();
               check("a_in_data", in_data_a, eb);
            end
         end
         if (run_a && !run_seen_a) begin
            run_seen_a = 1'b1;
            run_at_a   = ncyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   // Drives one byte for one cycle. gap=0 leaves rx_ready high so the next
   // call produces a back-to-back pulse.
   task automatic send_byte(input logic [7:0] d, input logic f, input int gap);
      @(negedge clk);
      rx_data  = d;
      rx_ferr  = f;
      rx_ready = 1'b1;
      if (gap > 0) begin
         @(negedge clk);
         rx_ready = 1'b0;
         rx_ferr  = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8], 1'b0, gap);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_ready = 1'b0;
         rx_ferr  = 1'b0;
      end
      #2;
   endtask

   task automatic reset_a();
      @(negedge clk);
      rx_ready = 1'b0;
      rstn_a   = 1'b0;
      repeat (2) @(negedge clk);
      rstn_a     = 1'b1;
      we_cnt_a   = 0;
      run_seen_a = 1'b0;
   endtask

   task automatic reset_b();
      @(negedge clk);
      rx_ready = 1'b0;
      rstn_b   = 1'b0;
      repeat (2) @(negedge clk);
      rstn_b   = 1'b1;
      we_cnt_b = 0;
   endtask

   // Two-word program on dut_a; gap selects spacing between rx_ready pulses.
   task automatic run_two_word(input string tag, input int gap);
      exp_a.push_back('{addr: 0, data: 32'h0000_0013});
      exp_a.push_back('{addr: 1, data: 32'hDEAD_BEEF});
      send_word(32'd2, gap);
      send_word(32'h0000_0013, gap);
      send_word(32'hDEAD_BEEF, gap);
      idle(4);
      check({tag, "_we_count"}, we_cnt_a, 2);
      check({tag, "_words_loaded"}, wl_a, 2);
      check({tag, "_cpu_run"}, run_a, 1'b1);
      check({tag, "_run_delay"}, run_at_a - last_we_a, 1);
      check({tag, "_load_err"}, err_a, 1'b0);
      check({tag, "_addr_hold"}, addr_a, 1);
      check({tag, "_wdata_hold"}, wdata_a, 32'hDEAD_BEEF);
      check({tag, "_we_low"}, we_a, 1'b0);
      check({tag, "_sb_empty"}, exp_a.size(), 0);
   endtask

   // ---------------------------------------------------------------------
   // Directed tests
   // ---------------------------------------------------------------------
   initial begin
      repeat (2) @(negedge clk);
      rstn_a = 1'b1;
      rstn_b = 1'b1;
      #2;
      check("rst_cpu_run", run_a, 1'b0);
      check("rst_load_err", err_a, 1'b0);
      check("rst_words", wl_a, 0);
      check("rst_in_valid", in_valid_a, 1'b0);
      check("rst_overrun", overrun_a, 1'b0);
      check("rst_wdata", wdata_a, 32'd0);

      // T1: two-word program, spaced bytes.
      reset_a();
      run_two_word("t1", 2);

      // T2: empty program releases the CPU right after the header.
      reset_a();
      for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0, 1);
      #2;
      check("t2_run_before", run_a, 1'b0);
      send_byte(8'h00, 1'b0, 0);
      idle(1);
      check("t2_run_after", run_a, 1'b1);
      check("t2_we_count", we_cnt_a, 0);
      check("t2_words", wl_a, 0);

      // T3: framing error after one of three words.
      reset_a();
      exp_a.push_back('{addr: 0, data: 32'h1234_5678});
      send_word(32'd3, 1);
      send_word(32'h1234_5678, 1);
      send_byte(8'hAA, 1'b1, 1);
      send_word(32'h1122_3344, 0);
      idle(3);
      check("t3_load_err", err_a, 1'b1);
      check("t3_cpu_run", run_a, 1'b0);
      check("t3_we_count", we_cnt_a, 1);
      check("t3_words", wl_a, 1);
      check("t3_sb_empty", exp_a.size(), 0);

      // T4: run-mode buffer.
      reset_a();
      in_ready = 1'b0;
      send_word(32'd0, 1);
      send_byte(8'h55, 1'b1, 1);
      #2;
      check("t4_ferr_dropped", in_valid_a, 1'b0);
      check("t4_ferr_no_ovr", overrun_a, 1'b0);
      exp_byte.push_back(8'h41);
      send_byte(8'h41, 1'b0, 1);
      #2;
      check("t4_valid", in_valid_a, 1'b1);
      check("t4_data", in_data_a, 8'h41);
      // Pop and new byte in the same cycle: replaces, no overrun.
      exp_byte.push_back(8'h43);
      @(negedge clk);
      in_ready = 1'b1;
      rx_data  = 8'h43;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      in_ready = 1'b0;
      #2;
      check("t4_replace_data", in_data_a, 8'h43);
      check("t4_replace_valid", in_valid_a, 1'b1);
      check("t4_no_overrun", overrun_a, 1'b0);
      // Buffer full: byte dropped.
      send_byte(8'h42, 1'b0, 1);
      #2;
      check("t4_overrun", overrun_a, 1'b1);
      check("t4_kept_data", in_data_a, 8'h43);
      @(negedge clk);
      in_ready = 1'b1;
      @(negedge clk);
      in_ready = 1'b0;
      #2;
      check("t4_popped", in_valid_a, 1'b0);
      check("t4_sb_empty", exp_byte.size(), 0);

      // T5a: ADDR_W=4, N=17 is too large.
      sel_b = 1'b1;
      reset_b();
      send_word(32'd17, 1);
      send_word(32'h0BAD_0BAD, 1);
      idle(2);
      check("t5_big_err", err_b, 1'b1);
      check("t5_big_run", run_b, 1'b0);
      check("t5_big_we", we_cnt_b, 0);
      check("t5_big_words", wl_b, 0);

      // T5b: N=16 = 2**ADDR_W is the largest legal program.
      reset_b();
      send_word(32'd16, 1);
      for (int i = 0; i < 16; i++) begin
         exp_b.push_back('{addr: i, data: 32'hA500_0000 | 32'(i)});
         send_word(32'hA500_0000 | 32'(i), 0);
      end
      idle(3);
      check("t5_max_words", wl_b, 16);
      check("t5_max_run", run_b, 1'b1);
      check("t5_max_err", err_b, 1'b0);
      check("t5_max_we", we_cnt_b, 16);
      check("t5_max_sb", exp_b.size(), 0);
      sel_b = 1'b0;

      // T5c: reset in the middle of a load, then a clean reload.
      reset_a();
      exp_a.push_back('{addr: 0, data: 32'hCAFE_F00D});
      send_word(32'd2, 1);
      send_word(32'hCAFE_F00D, 1);
      send_byte(8'h01, 1'b0, 1);
      send_byte(8'h02, 1'b0, 1);
      @(negedge clk);
      rstn_a = 1'b0;
      #1;
      check("t5_rst_words", wl_a, 0);
      check("t5_rst_wdata", wdata_a, 32'd0);
      check("t5_rst_run", run_a, 1'b0);
      check("t5_rst_we", we_a, 1'b0);
      repeat (2) @(negedge clk);
      rstn_a     = 1'b1;
      we_cnt_a   = 0;
      run_seen_a = 1'b0;
      run_two_word("t5_reload", 1);

      // T6: rx_ready every cycle.
      reset_a();
      run_two_word("t6", 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
